// File: rtl/stack_game_ctrl_pkg.sv
// Shared definitions for the stacker game sequencing controller:
// state encoding, board geometry and the initial block bitmap helper.
package stack_game_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_MOVE  = 3'd1,
      ST_LOCK  = 3'd2,
      ST_CHECK = 3'd3,
      ST_WIN   = 3'd4,
      ST_LOSE  = 3'd5
   } state_e;

   localparam logic [2:0] LINE_MAX  = 3'd7;
   localparam int         COLS      = 8;
   localparam logic       DIR_LEFT  = 1'b0;
   localparam logic       DIR_RIGHT = 1'b1;

   // Bitmap with the lowest w columns set, i.e. (1 << w) - 1 clipped to the row.
   function automatic logic [COLS-1:0] block_init(input int unsigned w);
      logic [COLS-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < COLS; i++) begin
         if (i < w) begin
            m[i] = 1'b1;
         end else begin
            m[i] = 1'b0;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/stack_game_ctrl_step_timer.sv
// Step timer for the sliding block: counts enabled cycles and emits a
// single-cycle tick on the last cycle of each period.
// Optional feature macro: STACK_SPEEDUP_EN (period halves every two lines).
module stack_game_ctrl_step_timer
   import stack_game_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        en,
`ifdef STACK_SPEEDUP_EN
   input  logic [2:0]  line,
`endif
   input  logic [23:0] period,
   output logic        tick
);

   logic [23:0] cnt_q;
   logic [23:0] cnt_d;
   logic [23:0] eff_period;
   logic [23:0] last_cnt;

   // Effective period for the current line and the terminal count value.
   always_comb begin
`ifdef STACK_SPEEDUP_EN
      eff_period = period >> line[2:1];
`else
      eff_period = period;
`endif
      last_cnt = eff_period - 24'd1;
      tick     = en & (cnt_q == last_cnt);
   end

   // Next count: clear wins, wrap to zero on tick, otherwise count while enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = 24'd0;
      end else if (tick) begin
         cnt_d = 24'd0;
      end else if (en) begin
         cnt_d = cnt_q + 24'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= 24'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/stack_game_ctrl.sv
// Stacker game sequencing controller: slides the active block across the
// 8-column row, locks it on a button press and advances, loses or wins
// based on the comparator's stacked result.
// Optional feature macro: STACK_SPEEDUP_EN (handled inside the step timer).
module stack_game_ctrl
   import stack_game_ctrl_pkg::*;
#(
   parameter int unsigned STEP_DIV = 12_500_000,
   parameter int unsigned BLOCK_W  = 3
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       btn,
   input  logic       stacked,
   output logic [2:0] line_num,
   output logic [7:0] block_loc,
   output logic       game_over,
   output logic       win
);

   localparam logic [COLS-1:0] BLOCK_INIT = block_init(BLOCK_W);
   localparam logic [23:0]     PERIOD     = 24'(STEP_DIV);

   state_e     state_q, state_d;
   logic [2:0] line_q, line_d;
   logic [7:0] block_q, block_d;
   logic       dir_q, dir_d;
   logic       btn_q, btn_d;
   logic       game_over_q, game_over_d;
   logic       win_q, win_d;

   logic       press;
   logic       tick;
   logic       timer_clr;
   logic       timer_en;

   // Rising-edge detect and timer control; the counter only runs in MOVE and
   // restarts from zero whenever MOVE is (re)entered or a press locks the block.
   always_comb begin
      btn_d     = btn;
      press     = btn & ~btn_q;
      timer_en  = (state_q == ST_MOVE);
      timer_clr = (state_q != ST_MOVE) | press;
   end

   stack_game_ctrl_step_timer u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (timer_clr),
      .en     (timer_en),
`ifdef STACK_SPEEDUP_EN
      .line   (line_q),
`endif
      .period (PERIOD),
      .tick   (tick)
   );

   // Next-state, line, block shifter and status flags.
   always_comb begin
      state_d     = state_q;
      line_d      = line_q;
      block_d     = block_q;
      dir_d       = dir_q;
      game_over_d = game_over_q;
      win_d       = win_q;
      case (state_q)
         ST_IDLE, ST_WIN, ST_LOSE: begin
            if (start) begin
               state_d     = ST_MOVE;
               line_d      = 3'd0;
               block_d     = BLOCK_INIT;
               dir_d       = DIR_LEFT;
               game_over_d = 1'b0;
               win_d       = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         ST_MOVE: begin
            if (press) begin
               // A press freezes the block even if a step is due this cycle.
               state_d = ST_LOCK;
            end else if (tick) begin
               if (dir_q == DIR_LEFT) begin
                  if (!block_q[7]) begin
                     block_d = {block_q[6:0], 1'b0};
                  end else begin
                     dir_d   = DIR_RIGHT;
                     block_d = {1'b0, block_q[7:1]};
                  end
               end else begin
                  if (!block_q[0]) begin
                     block_d = {1'b0, block_q[7:1]};
                  end else begin
                     dir_d   = DIR_LEFT;
                     block_d = {block_q[6:0], 1'b0};
                  end
               end
            end else begin
               state_d = ST_MOVE;
            end
         end
         ST_LOCK: begin
            if (line_q == 3'd0) begin
               // The base line has nothing to compare against; the comparator
               // captures it as the stack and play continues from here.
               state_d = ST_MOVE;
               line_d  = 3'd1;
            end else begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (!stacked) begin
               state_d     = ST_LOSE;
               game_over_d = 1'b1;
            end else if (line_q == LINE_MAX) begin
               state_d = ST_WIN;
               win_d   = 1'b1;
            end else begin
               state_d = ST_MOVE;
               line_d  = line_q + 3'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         line_q      <= 3'd0;
         block_q     <= 8'h00;
         dir_q       <= DIR_LEFT;
         btn_q       <= 1'b0;
         game_over_q <= 1'b0;
         win_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         line_q      <= line_d;
         block_q     <= block_d;
         dir_q       <= dir_d;
         btn_q       <= btn_d;
         game_over_q <= game_over_d;
         win_q       <= win_d;
      end
   end

   assign line_num  = line_q;
   assign block_loc = block_q;
   assign game_over = game_over_q;
   assign win       = win_q;

endmodule

// File: tb/tb_stack_game_ctrl.sv
// Self-checking bench for stack_game_ctrl (STEP_DIV=4, BLOCK_W=3).
// Vectors carry inputs for one cycle and the outputs expected just after
// the following rising edge; expectations go through a scoreboard queue.
`timescale 1ns/1ps
module tb_stack_game_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       btn = 1'b0;
   logic       stacked = 1'b0;
   logic [2:0] line_num;
   logic [7:0] block_loc;
   logic       game_over;
   logic       win;

   int n_checks = 0;
   int n_fail   = 0;
   int vidx     = 0;

   typedef struct packed {
      logic       r;
      logic       s;
      logic       b;
      logic       st;
      logic [2:0] l;
      logic [7:0] blk;
      logic       go;
      logic       wn;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];

   // Sliding sequence from 8'h07 with BLOCK_W=3: reverses at 8'hE0.
   logic [7:0] slide_pat [8] = '{8'h07, 8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'h70, 8'h38};

   stack_game_ctrl #(.STEP_DIV(4), .BLOCK_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .btn       (btn),
      .stacked   (stacked),
      .line_num  (line_num),
      .block_loc (block_loc),
      .game_over (game_over),
      .win       (win)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h expected %h", name, vidx, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      vec_t e;
      @(negedge clk);
      rst_n   = v.r;
      start   = v.s;
      btn     = v.b;
      stacked = v.st;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("line_num",  {5'b0, line_num},  {5'b0, e.l});
      chk("block_loc", block_loc,         e.blk);
      chk("game_over", {7'b0, game_over}, {7'b0, e.go});
      chk("win",       {7'b0, win},       {7'b0, e.wn});
      vidx++;
   endtask

   task automatic add(input logic r, input logic s, input logic b, input logic st,
                      input logic [2:0] l, input logic [7:0] blk, input logic go, input logic wn);
      vec_t v;
      v = '{r: r, s: s, b: b, st: st, l: l, blk: blk, go: go, wn: wn};
      tbl.push_back(v);
   endtask

   task automatic drv(input logic r, input logic s, input logic b, input logic st,
                      input logic [2:0] l, input logic [7:0] blk, input logic go, input logic wn);
      vec_t v;
      v = '{r: r, s: s, b: b, st: st, l: l, blk: blk, go: go, wn: wn};
      apply(v);
   endtask

`ifdef STACK_SPEEDUP_EN
   logic       f_start = 1'b0;
   logic       f_btn = 1'b0;
   logic       f_stacked = 1'b0;
   logic [2:0] f_line;
   logic [7:0] f_block;
   logic       f_go;
   logic       f_win;

   stack_game_ctrl #(.STEP_DIV(8), .BLOCK_W(3)) dut_fast (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (f_start),
      .btn       (f_btn),
      .stacked   (f_stacked),
      .line_num  (f_line),
      .block_loc (f_block),
      .game_over (f_go),
      .win       (f_win)
   );

   task automatic fdrv(input logic s, input logic b, input logic st,
                       input logic [2:0] l, input logic [7:0] blk);
      @(negedge clk);
      rst_n     = 1'b1;
      start     = 1'b0;
      btn       = 1'b0;
      stacked   = 1'b0;
      f_start   = s;
      f_btn     = b;
      f_stacked = st;
      @(posedge clk);
      #1;
      chk("fast_line",  {5'b0, f_line}, {5'b0, l});
      chk("fast_block", f_block,        blk);
      vidx++;
   endtask
`endif

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset, then free sliding with a stray start mid-game (ignored).
      add(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, slide_pat[0], 1'b0, 1'b0);
      for (int k = 1; k < 32; k++) begin
         add(1'b1, (k == 10), 1'b0, 1'b0, 3'd0, slide_pat[k / 4], 1'b0, 1'b0);
      end
      // Reset mid-game, then lose on line 1 (0E against a stack of 07).
      add(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h07, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h07, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 8'h07, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 8'h07, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 8'h07, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 8'h07, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 8'h0E, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 8'h0E, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 8'h0E, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 8'h0E, 1'b1, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 8'h0E, 1'b1, 1'b0);
      add(1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 8'h0E, 1'b1, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h07, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h07, 1'b0, 1'b0);

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i]);
      end

      // Press coincident with a step tick on line 0, then advance line 1 -> 2.
      drv(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
      drv(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
      drv(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h07, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         drv(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h07, 1'b0, 1'b0);
      end
      drv(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h07, 1'b0, 1'b0);
      drv(1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 8'h07, 1'b0, 1'b0);
      drv(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 8'h07, 1'b0, 1'b0);
      drv(1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 8'h07, 1'b0, 1'b0);
      drv(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 8'h07, 1'b0, 1'b0);
      drv(1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 8'h07, 1'b0, 1'b0);
      drv(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 8'h07, 1'b0, 1'b0);

      // Eight aligned presses to a win.
      drv(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
      drv(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
      drv(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h07, 1'b0, 1'b0);
      drv(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h07, 1'b0, 1'b0);
      drv(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 8'h07, 1'b0, 1'b0);
      for (int l = 1; l < 8; l++) begin
         drv(1'b1, 1'b0, 1'b1, 1'b0, 3'(l), 8'h07, 1'b0, 1'b0);
         drv(1'b1, 1'b0, 1'b0, 1'b0, 3'(l), 8'h07, 1'b0, 1'b0);
         if (l < 7) begin
            drv(1'b1, 1'b0, 1'b0, 1'b1, 3'(l + 1), 8'h07, 1'b0, 1'b0);
         end else begin
            drv(1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 8'h07, 1'b0, 1'b1);
         end
      end
      for (int k = 0; k < 3; k++) begin
         drv(1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 8'h07, 1'b0, 1'b1);
      end

      // Restart from WIN, lock line 0, then hold the button: no further locks.
      drv(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h07, 1'b0, 1'b0);
      drv(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h07, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) begin
         drv(1'b1, 1'b0, 1'b1, 1'b0, 3'd1, slide_pat[k / 4], 1'b0, 1'b0);
      end

`ifdef STACK_SPEEDUP_EN
      // STEP_DIV=8: line 2 steps every 4 cycles.
      fdrv(1'b1, 1'b0, 1'b0, 3'd0, 8'h07);
      fdrv(1'b0, 1'b1, 1'b0, 3'd0, 8'h07);
      fdrv(1'b0, 1'b0, 1'b0, 3'd1, 8'h07);
      fdrv(1'b0, 1'b1, 1'b0, 3'd1, 8'h07);
      fdrv(1'b0, 1'b0, 1'b0, 3'd1, 8'h07);
      fdrv(1'b0, 1'b0, 1'b1, 3'd2, 8'h07);
      for (int k = 1; k < 8; k++) begin
         fdrv(1'b0, 1'b0, 1'b0, 3'd2, slide_pat[k / 4]);
      end
`endif

      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard: %0d expected entries left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
